// File: rtl/mult_share_ctrl_pkg.sv
// Shared definitions for the two-requester shift-add multiplier controller:
// FSM encoding, requester IDs and the default operand width.
package mult_share_ctrl_pkg;

    localparam int DEFAULT_N = 6;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Requester/consumer handshake bundle for mult_share_ctrl; the master drives
// operands and accepts results, the slave is the controller itself.
interface mult_share_ctrl_if
    import mult_share_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
);

    logic           req0_valid;
    logic           req0_ready;
    logic [N-1:0]   req0_a;
    logic [N-1:0]   req0_b;

    logic           req1_valid;
    logic           req1_ready;
    logic [N-1:0]   req1_a;
    logic [N-1:0]   req1_b;

    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] res_product;
    logic           res_id;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_product, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_product, res_id
    );

endinterface

// File: rtl/mult_share_ctrl_datapath.sv
// Right-shift shift-add multiplier datapath: operand registers, accumulator and
// iteration counter, sequenced by load/step from the controller.
module seq_mult_datapath
    import mult_share_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic           i_load,
    input  logic           i_step,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_acc,
    output logic           o_last
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic [N:0]     w_sum;

    // The sum keeps its carry bit so the right shift never loses it.
    always_comb begin
        w_sum = {1'b0, r_acc[2*N-1:N]} + (r_b[0] ? {1'b0, r_a} : {(N+1){1'b0}});
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= CW'(N);
        end else if (i_step) begin
            r_acc <= {w_sum, r_acc[N-1:1]};
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter and sequencing FSM sharing one shift-add multiplier
// between two requesters; the product is held with its owner's ID until taken.
module mult_share_ctrl
    import mult_share_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic          Clock,
    input  logic          Resetn,
    mult_share_ctrl_if.slave bus,
    output logic          busy
);

    state_t         r_state;
    logic           r_lastServed;
    logic           r_resValid;
    logic           r_resId;
    logic           r_busy;

    logic           w_win;
    logic           w_handshake;
    logic           w_step;
    logic           w_last;
    logic [N-1:0]   w_a;
    logic [N-1:0]   w_b;
    logic [2*N-1:0] w_acc;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_win = REQ0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_win = ~r_lastServed;
        end else if (bus.req1_valid) begin
            w_win = REQ1;
        end
    end

    assign w_handshake    = (r_state == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
    assign w_step         = (r_state == ST_RUN);
    assign w_a            = (w_win == REQ1) ? bus.req1_a : bus.req0_a;
    assign w_b            = (w_win == REQ1) ? bus.req1_b : bus.req0_b;
    assign bus.req0_ready = w_handshake && (w_win == REQ0);
    assign bus.req1_ready = w_handshake && (w_win == REQ1);

    seq_mult_datapath #(.N(N)) u_datapath (
        .Clock  (Clock),
        .Resetn (Resetn),
        .i_load (w_handshake),
        .i_step (w_step),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_acc  (w_acc),
        .o_last (w_last)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state      <= ST_IDLE;
            r_lastServed <= REQ1;
            r_resValid   <= 1'b0;
            r_resId      <= REQ0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_state      <= ST_RUN;
                        r_resId      <= w_win;
                        r_lastServed <= w_win;
                        r_busy       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_state    <= ST_DONE;
                        r_resValid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        r_state    <= ST_IDLE;
                        r_resValid <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.res_valid   = r_resValid;
    assign bus.res_product = w_acc;
    assign bus.res_id      = r_resId;
    assign busy            = r_busy;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: directed scenarios plus a random
// sweep of every operand pair, checked against a transaction-level model.
module tb_mult_share_ctrl;
    import mult_share_ctrl_pkg::*;

    localparam int N    = 6;
    localparam int MASK = (1 << N) - 1;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    logic busy;

    mult_share_ctrl_if #(.N(N)) busIf ();

    mult_share_ctrl #(.N(N)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (busIf),
        .busy   (busy)
    );

    always #5 Clock = ~Clock;

    int checkCount = 0;
    int errorCount = 0;

    // Model: 0 = idle, 1 = computing (mCount edges left), 2 = result held.
    int   mPhase  = 0;
    int   mCount  = 0;
    int   mProd   = 0;
    bit   mId     = 1'b0;
    bit   mLast   = 1'b1;
    bit   hs0     = 1'b0;
    bit   hs1     = 1'b0;
    bit   accepted = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mCount = 0;
        mLast  = 1'b1;
    endtask

    task automatic driveIdleInputs();
        busIf.req0_valid = 1'b0;
        busIf.req0_a     = '0;
        busIf.req0_b     = '0;
        busIf.req1_valid = 1'b0;
        busIf.req1_a     = '0;
        busIf.req1_b     = '0;
        busIf.res_ready  = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_res_valid"}, busIf.res_valid, 0);
        checkOutput({tag, "_product"}, busIf.res_product, 0);
        checkOutput({tag, "_res_id"}, busIf.res_id, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_ready0"}, busIf.req0_ready, 0);
        checkOutput({tag, "_ready1"}, busIf.req1_ready, 0);
    endtask

    task automatic doReset();
        @(negedge Clock);
        driveIdleInputs();
        Resetn = 1'b0;
        modelReset();
        repeat (2) @(negedge Clock);
        checkAllZero("reset");
        Resetn = 1'b1;
    endtask

    // One clock: drive inputs, check outputs against the model, then advance it.
    task automatic applyStimulus(input bit v0, input int a0, input int b0,
                                 input bit v1, input int a1, input int b1, input bit rr);
        bit win;
        bit e0;
        bit e1;
        @(negedge Clock);
        busIf.req0_valid = v0;
        busIf.req0_a     = N'(a0 & MASK);
        busIf.req0_b     = N'(b0 & MASK);
        busIf.req1_valid = v1;
        busIf.req1_a     = N'(a1 & MASK);
        busIf.req1_b     = N'(b1 & MASK);
        busIf.res_ready  = rr;
        #1;
        win = (v0 && v1) ? !mLast : (v1 && !v0);
        e0  = (mPhase == 0) && v0 && !win;
        e1  = (mPhase == 0) && v1 && win;
        checkOutput("req0_ready", busIf.req0_ready, e0);
        checkOutput("req1_ready", busIf.req1_ready, e1);
        checkOutput("res_valid", busIf.res_valid, mPhase == 2);
        checkOutput("busy", busy, mPhase != 0);
        if (mPhase == 2) begin
            checkOutput("res_product", busIf.res_product, mProd);
            checkOutput("res_id", busIf.res_id, mId);
        end
        hs0      = e0;
        hs1      = e1;
        accepted = 1'b0;
        @(posedge Clock);
        if (mPhase == 0) begin
            if (e0 || e1) begin
                mProd  = win ? (a1 & MASK) * (b1 & MASK) : (a0 & MASK) * (b0 & MASK);
                mId    = win;
                mLast  = win;
                mPhase = 1;
                mCount = N;
            end
        end else if (mPhase == 1) begin
            mCount--;
            if (mCount == 0) mPhase = 2;
        end else if (rr) begin
            mPhase   = 0;
            accepted = 1'b1;
        end
    endtask

    task automatic idleCycles(input int n, input bit rr);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, rr);
    endtask

    initial begin
        int nextPair;
        int pair0;
        int pair1;
        bit have0;
        bit have1;
        int doneCount;
        int cyc;

        driveIdleInputs();
        doReset();

        // Single request 13*11 = 143 from requester 0.
        applyStimulus(1, 13, 11, 0, 0, 0, 0);
        idleCycles(N, 0);
        idleCycles(2, 1);

        // Simultaneous requests after reset: req0 first, then alternation.
        doReset();
        for (int i = 0; i < 4 * (N + 2); i++) applyStimulus(1, 63, 63, 1, 5, 0, 1);
        idleCycles(N + 2, 1);

        // Result held under backpressure while both requesters wait.
        applyStimulus(1, 20, 30, 0, 0, 0, 0);
        for (int i = 0; i < N + 10; i++) applyStimulus(1, 33, 44, 1, 55, 22, 0);
        idleCycles(2, 1);

        // Operands altered during RUN must not affect the 7*9 result.
        applyStimulus(1, 7, 9, 0, 0, 0, 0);
        for (int i = 0; i < N - 1; i++) applyStimulus(1, 50, 40, 1, 61, 62, 0);
        idleCycles(3, 1);

        // Asynchronous reset in the third RUN cycle discards the operation.
        applyStimulus(1, 40, 50, 0, 0, 0, 0);
        idleCycles(2, 0);
        @(negedge Clock);
        driveIdleInputs();
        #1;
        Resetn = 1'b0;
        #1;
        checkAllZero("async_reset");
        modelReset();
        @(negedge Clock);
        Resetn = 1'b1;
        applyStimulus(1, 2, 3, 0, 0, 0, 0);
        idleCycles(N + 2, 1);

        // Random sweep over all operand pairs, pair index = {A, B}.
        doReset();
        nextPair  = 0;
        pair0     = nextPair++;
        pair1     = nextPair++;
        have0     = 1'b1;
        have1     = 1'b1;
        doneCount = 0;
        cyc       = 0;
        while (doneCount < 4096 && cyc < 80000) begin
            applyStimulus(have0 && ($urandom_range(3) != 0), pair0 >> N, pair0 & MASK,
                          have1 && ($urandom_range(3) != 0), pair1 >> N, pair1 & MASK,
                          $urandom_range(3) != 0);
            if (hs0) begin
                if (nextPair < 4096) pair0 = nextPair++;
                else have0 = 1'b0;
            end
            if (hs1) begin
                if (nextPair < 4096) pair1 = nextPair++;
                else have1 = 1'b0;
            end
            if (accepted) doneCount++;
            cyc++;
        end
        checkOutput("all_products_done", doneCount, 4096);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
